// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : main control FSM for the multicycle MIPS datapath
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             branch,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_w;
  logic             illegal_w;

  // Raw enables before the reset gate.
  logic pcwrite_w, branch_w, memwrite_w, irwrite_w, regwrite_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retire_w  = 1'b0;
    illegal_w = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_w = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d  = S_FETCH;
        retire_w = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_w = 1'b1;
        end
      end
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d  = S_FETCH;
        retire_w = 1'b1;
      end
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  assign cnt_d = retire_w ? (cnt_q + CNT_ONE) : cnt_q;

  always_comb begin
    pcwrite_w  = 1'b0;
    branch_w   = 1'b0;
    memwrite_w = 1'b0;
    irwrite_w  = 1'b0;
    regwrite_w = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    case (state_q)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite_w = mem_ready;
        pcwrite_w = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_w = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_w = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_w = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_w = 1'b1;
      end
      S_ADDIWB: regwrite_w = 1'b1;
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_w = 1'b1;
      end
      // Unreachable codes look like a stalled fetch: FETCH selects, no enables.
      default: alusrcb = 2'b01;
    endcase
  end

  // Enables are qualified by rst_n so a held reset never leaks mem_ready through.
  assign pcwrite     = pcwrite_w  & rst_n;
  assign branch      = branch_w   & rst_n;
  assign memwrite    = memwrite_w & rst_n;
  assign irwrite     = irwrite_w  & rst_n;
  assign regwrite    = regwrite_w & rst_n;
  assign illegal_op  = illegal_w  & rst_n;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl; a second instance with a
// 2-bit counter runs the same stimulus to exercise the count wrap.
`default_nettype none

module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  op = 6'b0;
  logic        mem_ready = 1'b1;

  logic        pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic        alusrca, illegal_op;
  logic [1:0]  alusrcb, aluop, pcsrc;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        s_pcwrite, s_branch, s_iord, s_memwrite, s_irwrite, s_regdst, s_memtoreg;
  logic        s_regwrite, s_alusrca, s_illegal_op;
  logic [1:0]  s_alusrcb, s_aluop, s_pcsrc;
  logic [3:0]  s_state;
  logic [1:0]  s_instr_count;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
    .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  multicycle_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(s_pcwrite), .branch(s_branch), .iord(s_iord), .memwrite(s_memwrite),
    .irwrite(s_irwrite), .regdst(s_regdst), .memtoreg(s_memtoreg), .regwrite(s_regwrite),
    .alusrca(s_alusrca), .alusrcb(s_alusrcb), .aluop(s_aluop), .pcsrc(s_pcsrc),
    .illegal_op(s_illegal_op), .state(s_state), .instr_count(s_instr_count)
  );

  always #5 clk = ~clk;

  // {pcwrite,branch,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,aluop,pcsrc,illegal_op}
  localparam logic [15:0] C_FETCH1 = 16'b1_0_0_0_1_0_0_0_0_01_00_00_0;
  localparam logic [15:0] C_FETCH0 = 16'b0_0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [15:0] C_DEC    = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [15:0] C_DECILL = 16'b0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [15:0] C_MEMADR = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] C_MEMRD  = 16'b0_0_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] C_MEMWB  = 16'b0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [15:0] C_MEMWR  = 16'b0_0_1_1_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] C_EXEC   = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [15:0] C_ALUWB  = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [15:0] C_BR     = 16'b0_1_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] C_ADDIX  = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] C_ADDIWB = 16'b0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [15:0] C_JUMP   = 16'b1_0_0_0_0_0_0_0_0_00_00_10_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, RT = 6'b000000, ADDI = 6'b001000, BAD = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctrl;
    int          cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  wire [15:0] ctrl_w = {pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg,
                        regwrite, alusrca, alusrcb, aluop, pcsrc, illegal_op};

  task automatic add(input logic [5:0] o, input logic m, input logic [3:0] s,
                     input logic [15:0] c, input int n);
    vec_t v;
    v.op = o; v.mr = m; v.st = s; v.ctrl = c; v.cnt = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] st,
                           input logic [15:0] c, input int n);
    logic [1:0] small_exp;
    small_exp = n[1:0];
    check({tag, " state"}, {28'b0, state}, {28'b0, st});
    check({tag, " ctrl"}, {16'b0, ctrl_w}, {16'b0, c});
    check({tag, " count"}, instr_count, n);
    check({tag, " count2"}, {30'b0, s_instr_count}, {30'b0, small_exp});
  endtask

  initial begin
    // lw, all ready; op changes in MEMRD must be ignored
    add(LW,  1, 0, C_FETCH1, 0);
    add(LW,  1, 1, C_DEC,    0);
    add(LW,  1, 2, C_MEMADR, 0);
    add(RT,  1, 3, C_MEMRD,  0);
    add(RT,  1, 4, C_MEMWB,  0);
    // sw with one fetch wait and two MEMWR waits
    add(SW,  0, 0, C_FETCH0, 1);
    add(SW,  1, 0, C_FETCH1, 1);
    add(SW,  1, 1, C_DEC,    1);
    add(SW,  1, 2, C_MEMADR, 1);
    add(SW,  0, 5, C_MEMWR,  1);
    add(SW,  0, 5, C_MEMWR,  1);
    add(SW,  1, 5, C_MEMWR,  1);
    // beq
    add(BEQ, 1, 0, C_FETCH1, 2);
    add(BEQ, 1, 1, C_DEC,    2);
    add(BEQ, 1, 8, C_BR,     2);
    // j
    add(JMP, 1, 0, C_FETCH1, 3);
    add(JMP, 1, 1, C_DEC,    3);
    add(JMP, 1, 11, C_JUMP,  3);
    // R-type; the 2-bit counter reads 0 here after wrapping
    add(RT,  1, 0, C_FETCH1, 4);
    add(RT,  1, 1, C_DEC,    4);
    add(RT,  1, 6, C_EXEC,   4);
    add(RT,  1, 7, C_ALUWB,  4);
    // addi
    add(ADDI, 1, 0, C_FETCH1, 5);
    add(ADDI, 1, 1, C_DEC,    5);
    add(ADDI, 1, 9, C_ADDIX,  5);
    add(ADDI, 1, 10, C_ADDIWB, 5);
    // illegal opcode: one pulse, no retire
    add(BAD, 1, 0, C_FETCH1, 6);
    add(BAD, 1, 1, C_DECILL, 6);
    add(LW,  1, 0, C_FETCH1, 6);
    // lw stalled in MEMRD, then reset hits below
    add(LW,  1, 1, C_DEC,    6);
    add(LW,  1, 2, C_MEMADR, 6);
    add(LW,  0, 3, C_MEMRD,  6);
    add(LW,  0, 3, C_MEMRD,  6);

    // Reset held with mem_ready high: enables stay low
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_all("reset", 4'd0, C_FETCH0, 0);
    rst_n = 1'b1;
    #1;
    check_all("release", 4'd0, C_FETCH1, 0);

    foreach (vecs[i]) begin
      op = vecs[i].op;
      mem_ready = vecs[i].mr;
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl, vecs[i].cnt);
      @(posedge clk);
      @(negedge clk);
    end

    // Still in MEMRD; assert reset between edges and expect an immediate abort
    #1;
    check_all("pre_reset", 4'd3, C_MEMRD, 6);
    mem_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 4'd0, C_FETCH0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_all("held_reset", 4'd0, C_FETCH0, 0);
    rst_n = 1'b1;
    #1;
    check_all("rerelease", 4'd0, C_FETCH1, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_all("refetch", 4'd1, C_DEC, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
